// File: rtl/p2s_pkg.sv
// p2s shared configuration: datapath widths, beat count, buffer depth and FSM encoding.
// Build option: define P2S_DOUBLE_BUF_EN for a two-entry block buffer (default: one entry).
package p2s_pkg;

    // Ceiling log2, minimum result 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Beats needed to carry one 128-bit block at a given beat width.
    function automatic int unsigned div128(input int unsigned w);
        return 128 / w;
    endfunction

    localparam int unsigned IO_WIDTH     = 8;
    localparam int unsigned BLOCK_LENGTH = 128;
    localparam int unsigned ITER_NUM     = div128(IO_WIDTH);
    localparam int unsigned COUNT_WIDTH  = clog2(ITER_NUM);
    localparam int unsigned BLK_WIDTH    = BLOCK_LENGTH + 1;

`ifdef P2S_DOUBLE_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Same packing as the deserializer output: data above, eop tag in the LSB.
    typedef struct packed {
        logic [BLOCK_LENGTH-1:0] data;
        logic                    eop;
    } blk_t;

endpackage

// File: rtl/p2s_blk_buf.sv
// Small synchronous FIFO holding whole cipher blocks in front of the p2s shift register.
// Writes are ignored when full and reads when empty; clr empties it synchronously.
module p2s_blk_buf
    import p2s_pkg::*;
#(
    parameter int unsigned Width = BLK_WIDTH,
    parameter int unsigned Depth = DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (Depth > 1) ? clog2(Depth) : 1;
    localparam int unsigned CntW = clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointer and occupancy next-state; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (do_wr && !do_rd) begin
                count_d = count_q + CntW'(1);
            end else if (do_rd && !do_wr) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Block storage; cleared on reset so a stale entry can never be observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_wr && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/p2s.sv
// p2s: buffers 128-bit result blocks from the SM4 core and streams each out as ITER_NUM
// MSB-first beats with a valid/ready handshake, flagging eop on the last beat of a tagged block.
// Build option: P2S_DOUBLE_BUF_EN selects a two-entry block buffer (see p2s_pkg).
module p2s
    import p2s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg,
    input  logic                    blk_val_i,
    input  logic [BLOCK_LENGTH:0]   blk_i,
    output logic                    blk_rdy_o,
    input  logic                    out_rdy_i,
    output logic                    val_o,
    output logic                    eop_o,
    output logic [IO_WIDTH-1:0]     dat_o,
    output logic                    busy_o,
    output logic                    ovf_err
);

    state_e                   state_q, state_d;
    logic [BLOCK_LENGTH-1:0]  sreg_q, sreg_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     eop_flag_q, eop_flag_d;
    logic                     ovf_q, ovf_d;

    logic                     buf_wr;
    logic                     buf_rd;
    logic                     buf_empty;
    logic                     buf_full;
    blk_t                     buf_dout;
    logic                     last_beat;
    logic                     beat_done;

    // A block offered together with cfg is discarded, never stored.
    assign buf_wr    = blk_val_i && !buf_full && !cfg;
    assign last_beat = (cnt_q == COUNT_WIDTH'(ITER_NUM - 1));
    assign beat_done = (state_q == StShift) && out_rdy_i;

    p2s_blk_buf #(
        .Width (BLK_WIDTH),
        .Depth (DEPTH)
    ) u_blk_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg),
        .wr_en (buf_wr),
        .rd_en (buf_rd),
        .din   (blk_i),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full)
    );

    // FSM next-state: load from the buffer, shift on consumed beats, chain blocks without a bubble.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        eop_flag_d = eop_flag_q;
        ovf_d      = ovf_q;
        buf_rd     = 1'b0;

        if (cfg) begin
            state_d    = StIdle;
            sreg_d     = '0;
            cnt_d      = '0;
            eop_flag_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            if (blk_val_i && buf_full) begin
                ovf_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (!buf_empty) begin
                        buf_rd     = 1'b1;
                        sreg_d     = buf_dout.data;
                        eop_flag_d = buf_dout.eop;
                        cnt_d      = '0;
                        state_d    = StShift;
                    end
                end
                StShift: begin
                    if (beat_done) begin
                        if (!last_beat) begin
                            sreg_d = sreg_q << IO_WIDTH;
                            cnt_d  = cnt_q + COUNT_WIDTH'(1);
                        end else if (!buf_empty) begin
                            buf_rd     = 1'b1;
                            sreg_d     = buf_dout.data;
                            eop_flag_d = buf_dout.eop;
                            cnt_d      = '0;
                        end else begin
                            sreg_d     = '0;
                            cnt_d      = '0;
                            eop_flag_d = 1'b0;
                            state_d    = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, shift register, beat counter, eop tag and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            cnt_q      <= '0;
            eop_flag_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            eop_flag_q <= eop_flag_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs are pure functions of registered state, so they drop with reset immediately.
    always_comb begin
        val_o     = (state_q == StShift);
        dat_o     = val_o ? sreg_q[BLOCK_LENGTH-1 -: IO_WIDTH] : '0;
        eop_o     = val_o && last_beat && eop_flag_q;
        busy_o    = val_o || !buf_empty;
        blk_rdy_o = !buf_full;
        ovf_err   = ovf_q;
    end

endmodule

// File: tb/tb_p2s.sv
// Self-checking bench for p2s: scoreboard of expected beats fed by accepted blocks,
// a negedge monitor that compares every presented beat, plus directed boundary checks.
module tb_p2s;
    import p2s_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg = 1'b0;
    logic                  blk_val_i = 1'b0;
    logic [BLOCK_LENGTH:0] blk_i = '0;
    logic                  blk_rdy_o;
    logic                  out_rdy_i = 1'b0;
    logic                  val_o;
    logic                  eop_o;
    logic [IO_WIDTH-1:0]   dat_o;
    logic                  busy_o;
    logic                  ovf_err;

    typedef struct {
        logic [IO_WIDTH-1:0] dat;
        logic                eop;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  exp_ovf = 1'b0;
    int    run = 0;
    int    last_run = 0;
    bit    rnd_rdy = 1'b0;

    localparam logic [127:0] KNOWN = 128'h0123456789ABCDEF_FEDCBA9876543210;

    p2s dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg),
        .blk_val_i (blk_val_i),
        .blk_i     (blk_i),
        .blk_rdy_o (blk_rdy_o),
        .out_rdy_i (out_rdy_i),
        .val_o     (val_o),
        .eop_o     (eop_o),
        .dat_o     (dat_o),
        .busy_o    (busy_o),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a block becomes ITER_NUM beats, most significant slice first.
    task automatic push_block(input logic [BLOCK_LENGTH-1:0] d, input logic e);
        beat_t b;
        for (int i = 0; i < int'(ITER_NUM); i++) begin
            b.dat = d[BLOCK_LENGTH-1-IO_WIDTH*i -: IO_WIDTH];
            b.eop = e && (i == int'(ITER_NUM) - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare the presented beat, retire it when consumed, record new blocks.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || cfg) begin
                exp_q.delete();
                exp_ovf = 1'b0;
            end else begin
                chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
                chk("busy_o", 32'(busy_o), 32'(exp_q.size() != 0));
                if (exp_q.size() == 0) begin
                    chk("val_o_idle", 32'(val_o), 32'd0);
                end else if (val_o) begin
                    chk("dat_o", 32'(dat_o), 32'(exp_q[0].dat));
                    chk("eop_o", 32'(eop_o), 32'(exp_q[0].eop));
                    if (out_rdy_i) begin
                        void'(exp_q.pop_front());
                    end
                end else begin
                    chk("eop_o_nval", 32'(eop_o), 32'd0);
                end
                if (blk_val_i && blk_rdy_o) begin
                    push_block(blk_i[BLOCK_LENGTH:1], blk_i[0]);
                end else if (blk_val_i) begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    // Length of the most recent contiguous run of valid beats.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (val_o) begin
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_rdy_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a block only once the buffer can take it, hold valid for the accepting edge.
    task automatic offer(input logic [127:0] d, input logic e);
        int k;
        k = 0;
        while (!blk_rdy_o && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) chk("offer_timeout", 32'd1, 32'd0);
        blk_i     = {d, e};
        blk_val_i = 1'b1;
        @(posedge clk);
        #1;
        blk_val_i = 1'b0;
    endtask

    // Offer for exactly one cycle regardless of readiness.
    task automatic raw_offer(input logic [127:0] d, input logic e);
        blk_i     = {d, e};
        blk_val_i = 1'b1;
        @(posedge clk);
        #1;
        blk_val_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_o || val_o) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_timeout", 32'(k < 400), 32'd1);
        cycles(1);
    endtask

    task automatic pulse_cfg();
        cfg = 1'b1;
        @(posedge clk);
        #1;
        cfg = 1'b0;
    endtask

    // Stall the output, fill sreg and buffer, then offer one more block that must be dropped.
    task automatic fill_and_overflow();
        out_rdy_i = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            offer(rand128(), 1'b1);
        end
        chk("rdy_when_full", 32'(blk_rdy_o), 32'd0);
        raw_offer(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b1);
        @(negedge clk);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_val_o", 32'(val_o), 32'd0);
        chk("rst_eop_o", 32'(eop_o), 32'd0);
        chk("rst_dat_o", 32'(dat_o), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_blk_rdy", 32'(blk_rdy_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);

        // Single tagged block, no backpressure: one-cycle load latency, 16 contiguous beats
        out_rdy_i = 1'b1;
        offer(KNOWN, 1'b1);
        @(negedge clk);
        chk("latency_not_yet", 32'(val_o), 32'd0);
        @(negedge clk);
        chk("latency_first_val", 32'(val_o), 32'd1);
        chk("latency_first_dat", 32'(dat_o), 32'h01);
        @(posedge clk);
        #1;
        wait_idle();
        chk("run_single", 32'(last_run), 32'd16);

        // Back-to-back blocks: no valid gap across the block boundary
        offer(rand128(), 1'b1);
        chk("rdy_after_first", 32'(blk_rdy_o), 32'(DEPTH > 1));
        offer(rand128(), 1'b0);
        wait_idle();
        chk("run_double", 32'(last_run), 32'd32);

        // Stall on beat 3 of an untagged block: data holds while not consumed
        offer(KNOWN, 1'b0);
        cycles(4);
        out_rdy_i = 1'b0;
        @(negedge clk);
        chk("stall_hold_0", 32'(dat_o), 32'h67);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_hold_1", 32'(dat_o), 32'h67);
        @(posedge clk);
        #1;
        out_rdy_i = 1'b1;
        @(negedge clk);
        chk("stall_hold_2", 32'(dat_o), 32'h67);
        @(posedge clk);
        #1;
        wait_idle();

        // Overflow, partial drain, then flush
        fill_and_overflow();
        out_rdy_i = 1'b1;
        cycles(5);
        pulse_cfg();
        @(negedge clk);
        chk("cfg_val_o", 32'(val_o), 32'd0);
        chk("cfg_busy", 32'(busy_o), 32'd0);
        chk("cfg_ovf", 32'(ovf_err), 32'd0);
        @(posedge clk);
        #1;

        // Randomised traffic with random backpressure and occasional forced offers
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cycles($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                raw_offer(rand128(), 1'($urandom_range(0, 1)));
            end else begin
                offer(rand128(), 1'($urandom_range(0, 1)));
            end
        end
        rnd_rdy = 1'b0;
        cycles(1);
        out_rdy_i = 1'b1;
        wait_idle();
        pulse_cfg();
        cycles(2);

        // Asynchronous reset in the middle of a block
        fill_and_overflow();
        out_rdy_i = 1'b1;
        cycles(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_val_o", 32'(val_o), 32'd0);
        chk("arst_dat_o", 32'(dat_o), 32'd0);
        chk("arst_eop_o", 32'(eop_o), 32'd0);
        chk("arst_ovf", 32'(ovf_err), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_blk_rdy", 32'(blk_rdy_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(20);
        chk("post_rst_val", 32'(val_o), 32'd0);
        chk("post_rst_rdy", 32'(blk_rdy_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
